// File: rtl/fft8_bitrev_buffer.sv
// fft8_bitrev_buffer: 2x8 ping-pong buffer reordering float16 complex frames into bit-reversed order.
// Define FFT8_BITREV_NAN_FLAG_EN to add out_nan, a per-frame "contains NaN" flag.
module fft8_bitrev_buffer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_re,
    input  logic [15:0] in_im,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_re,
    output logic [15:0] out_im,
    output logic [2:0]  out_idx,
    output logic        out_last
`ifdef FFT8_BITREV_NAN_FLAG_EN
    ,
    output logic        out_nan
`endif
);
    logic [31:0] mem [0:15];
    logic [1:0]  full, full_nxt;
    logic        wr_bank, rd_bank;
    logic [2:0]  wr_cnt, rd_cnt, rd_addr;
    logic        in_fire, out_fire;

    assign in_ready  = ~full[wr_bank];
    assign out_valid = full[rd_bank];
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign rd_addr   = {rd_cnt[0], rd_cnt[1], rd_cnt[2]};
    assign out_idx   = rd_addr;
    assign out_last  = out_valid & (rd_cnt == 3'd7);
    assign {out_re, out_im} = mem[{rd_bank, rd_addr}];

    // Writer and reader only ever touch the same bank's full bit at different times.
    always_comb begin
        full_nxt = full;
        if (in_fire && wr_cnt == 3'd7) full_nxt[wr_bank] = 1'b1;
        if (out_fire && rd_cnt == 3'd7) full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (in_fire) mem[{wr_bank, wr_cnt}] <= {in_re, in_im};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt  <= 3'd0;
            rd_cnt  <= 3'd0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            full    <= 2'b00;
        end else begin
            if (in_fire) begin
                wr_cnt <= wr_cnt + 3'd1;
                if (wr_cnt == 3'd7) wr_bank <= ~wr_bank;
            end
            if (out_fire) begin
                rd_cnt <= rd_cnt + 3'd1;
                if (rd_cnt == 3'd7) rd_bank <= ~rd_bank;
            end
            full <= full_nxt;
        end
    end

`ifdef FFT8_BITREV_NAN_FLAG_EN
    function automatic logic is_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1f) && (x[9:0] != 10'd0);
    endfunction

    logic [1:0] nan_flag;
    logic       sample_nan;

    assign sample_nan = is_nan(in_re) | is_nan(in_im);
    assign out_nan    = out_valid & nan_flag[rd_bank];

    // The first write of a frame restarts the accumulation for that bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) nan_flag <= 2'b00;
        else if (in_fire) nan_flag[wr_bank] <= sample_nan | ((wr_cnt != 3'd0) & nan_flag[wr_bank]);
    end
`endif
endmodule

// File: tb/tb_fft8_bitrev_buffer.sv
// tb_fft8_bitrev_buffer: scoreboard bench for the bit-reversing ping-pong buffer.
module tb_fft8_bitrev_buffer;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [15:0] in_re = '0, in_im = '0;
    logic in_ready, out_valid, out_last;
    logic [15:0] out_re, out_im;
    logic [2:0] out_idx;
`ifdef FFT8_BITREV_NAN_FLAG_EN
    logic out_nan;
`endif

    fft8_bitrev_buffer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_idx(out_idx), .out_last(out_last)
`ifdef FFT8_BITREV_NAN_FLAG_EN
        , .out_nan(out_nan)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic [2:0]  idx;
        logic        last;
        logic        nan;
    } beat_t;

    beat_t exp_q[$];
    int checks = 0, failures = 0;
    int cyc = 0, last_pop = 0, pops = 0, acc_cyc = 0, stalls = 0;
    int wpos = 0;
    logic fnan = 1'b0, ready_hold = 1'b0, rnd_mode = 1'b0, done = 1'b0;
    logic [31:0] fb [8];
    logic [2:0] br [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic is_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1f) && (x[9:0] != 10'd0);
    endfunction

    task automatic send(input logic [15:0] re, input logic [15:0] im);
        beat_t b;
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_re = re;
        in_im = im;
        while (!in_ready && n < 200) begin
            n++;
            stalls++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=stalled required=accepted");
        end else begin
            acc_cyc = cyc;
            fb[wpos] = {re, im};
            fnan = fnan | is_nan(re) | is_nan(im);
            wpos++;
            if (wpos == 8) begin
                for (int j = 0; j < 8; j++) begin
                    b.re = fb[br[j]][31:16];
                    b.im = fb[br[j]][15:0];
                    b.idx = br[j];
                    b.last = (j == 7);
                    b.nan = fnan;
                    exp_q.push_back(b);
                end
                wpos = 0;
                fnan = 1'b0;
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial forever begin
        @(posedge clk);
        #2;
        out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : ready_hold;
    end

    // Monitor: stalled beats must already show the head of the queue; accepted beats pop it.
    initial forever begin
        beat_t b;
        @(negedge clk);
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual=re %h idx %0d required=none", out_re, out_idx);
            end else begin
                b = exp_q[0];
                chk(out_ready ? "out_re" : "stall_re", 32'(out_re), 32'(b.re));
                chk(out_ready ? "out_im" : "stall_im", 32'(out_im), 32'(b.im));
                chk(out_ready ? "out_idx" : "stall_idx", 32'(out_idx), 32'(b.idx));
                chk(out_ready ? "out_last" : "stall_last", 32'(out_last), 32'(b.last));
`ifdef FFT8_BITREV_NAN_FLAG_EN
                chk("out_nan", 32'(out_nan), 32'(b.nan));
`endif
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    pops++;
                    last_pop = cyc;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, first, p0, n;
        ready_hold = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_out_idx", 32'(out_idx), 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        for (int k = 0; k < 8; k++) send(16'h3C00 + 16'(k), 16'(k));
        chk("no_early_valid", 32'(out_valid), 0);
        a = acc_cyc;
        idle();
        drain();
        chk("first_frame_timing", 32'(last_pop - a), 8);

        ready_hold = 1'b0;
        repeat (3) @(posedge clk);
        stalls = 0;
        for (int k = 0; k < 16; k++) send(16'h4000 + 16'(k), 16'h8000 + 16'(k));
        chk("fill16_no_stall", 32'(stalls), 0);
        done = 1'b0;
        stalls = 0;
        fork
            begin
                send(16'h5110, 16'h5220);
                idle();
                done = 1'b1;
            end
        join_none
        @(negedge clk);
        chk("both_full_in_ready", 32'(in_ready), 0);
        chk("both_full_out_valid", 32'(out_valid), 1);
        repeat (5) @(negedge clk);
        chk("sample17_held", 32'(done), 0);
        ready_hold = 1'b1;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("sample17_accepted", 32'(done), 1);
        chk("sample17_stalled", 32'(stalls >= 6), 1);
        for (int k = 1; k < 8; k++) send(16'h5110 + 16'(k), 16'h5220 + 16'(k));
        idle();
        drain();

        stalls = 0;
        p0 = pops;
        first = 0;
        for (int f = 0; f < 10; f++)
            for (int k = 0; k < 8; k++) begin
                send(16'h1000 + 16'(f * 16 + k), ~(16'h1000 + 16'(f * 16 + k)));
                if (f == 0 && k == 0) first = acc_cyc;
            end
        idle();
        drain();
        chk("stream_no_stall", 32'(stalls), 0);
        chk("stream_beats", 32'(pops - p0), 80);
        chk("stream_rate", 32'(last_pop - first), 87);

        rnd_mode = 1'b1;
        for (int i = 0; i < 24; i++) send(16'h2000 + 16'(i), 16'h6000 - 16'(i));
        idle();
        drain();
        rnd_mode = 1'b0;

        for (int k = 0; k < 8; k++) send(16'h3800 + 16'(k), (k == 3) ? 16'h7E00 : 16'h0000);
        for (int k = 0; k < 8; k++) send(16'h3900 + 16'(k), (k == 3) ? 16'h7C00 : 16'h0001);
        idle();
        drain();

        for (int k = 0; k < 5; k++) send(16'hAA00 + 16'(k), 16'hBB00 + 16'(k));
        idle();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 1);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_out_idx", 32'(out_idx), 0);
        exp_q.delete();
        wpos = 0;
        fnan = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) send(16'hC000 + 16'(k), 16'hD000 + 16'(k));
        idle();
        drain();
        repeat (4) @(posedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
